pipeline_debug_controller: RTL
==============================

# pipeline_debug_controller

Sequencer that owns the instruction-fetch stage's memory write port and its stall line. It loads a program byte-by-byte from a serial byte stream into instruction memory, then runs the pipeline continuously or single-steps it. It reports completion of each command with a one-byte acknowledge. It sits between the UART byte interface and the fetch stage's write/stall inputs.

## Interface
- ADDR_WIDTH, 12: instruction memory address bits (byte addresses, 4K bytes).
- CMD_LOAD, 8'h4C: 'L', load program.
- CMD_RUN, 8'h52: 'R', run until halt.
- CMD_STEP, 8'h53: 'S', execute one cycle.
- i_clk  in  1  clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle pulse; i_rx_data valid.
- i_tx_ready  in  1  transmitter can accept o_tx_data.
- i_halted  in  1  pipeline has retired its halt instruction (level).
- o_write_instruction_mem  out  1  instruction memory write strobe.
- o_instruction_mem_addr  out  32  byte write address, zero-extended from ADDR_WIDTH.
- o_instruction_mem_data  out  32  write byte in [7:0], upper bits 0.
- o_stall  out  1  freezes PC and the fetch register.
- o_cpu_reset  out  1  one-cycle pipeline reset pulse.
- o_tx_data  out  8  acknowledge byte.
- o_tx_valid  out  1  o_tx_data valid; held until i_tx_ready.
- o_state  out  3  current state encoding, for status LEDs.

## Operation
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, ACK=4.
- IDLE: o_stall=1. Acts only on a byte with i_rx_valid=1.
  - CMD_LOAD: go to LOAD, clear the address counter, pulse o_cpu_reset.
  - CMD_RUN: go to RUN.
  - CMD_STEP: go to STEP.
  - Any other byte is ignored.
- LOAD: each valid byte is written at the address counter, then the counter increments.
  - Bytes are stored in arrival order; byte 4k is the MSB of word k.
  - A 32-bit shift register tracks the last four bytes.
  - When a byte completes an aligned word (counter[1:0]==3) and the word equals 32'hFFFFFFFF (halt sentinel), the byte is written and the state goes to ACK with 'K'.
  - If the counter writes the last address (2^ADDR_WIDTH-1) without a sentinel, the byte is written and the state goes to ACK with 'E'. The counter does not wrap.
- RUN: o_stall=0 until i_halted is sampled high, then go to ACK with 'H'. Received bytes are ignored.
- STEP: o_stall=0 for exactly one cycle, then go to ACK with 'D'. i_halted is ignored.
- ACK: o_stall=1 and o_tx_valid=1 with a stable o_tx_data. On o_tx_valid && i_tx_ready, go to IDLE. Received bytes are dropped.
- Reset in any state returns to IDLE; any in-flight load or ack is abandoned.

## Timing
- All outputs are registered.
- Reset values: o_state=IDLE, o_stall=1, o_write_instruction_mem=0, o_instruction_mem_addr=0, o_instruction_mem_data=0, o_cpu_reset=0, o_tx_valid=0, o_tx_data=0.
- Byte accepted at edge N: o_write_instruction_mem=1 for the cycle after N, with its address and data. The strobe is otherwise 0.
- CMD_LOAD accepted at edge N: o_cpu_reset=1 for the one cycle after N.
- CMD_RUN accepted at edge N: o_stall falls after edge N.
- i_halted high at edge M in RUN: o_stall rises after edge M and o_tx_valid rises after edge M.
- If i_halted is already high on entry to RUN, o_stall is low for exactly one cycle.
- STEP: the o_stall-low window is exactly one clock.
- Back-to-back rx pulses in LOAD are each written; throughput is one byte per clock.

## Configuration
- DEBUG_STEP_EN defined: CMD_STEP and the STEP state are present.
- DEBUG_STEP_EN undefined: the STEP state is not compiled. CMD_STEP is ignored in IDLE like any unknown byte. The o_state encoding is unchanged (3 is never produced).

## Test plan
- Reset mid-LOAD after 5 bytes -> next cycle o_state=0, o_stall=1, no write strobe; a new 'L' restarts at address 0.
- 'L' then bytes 20,01,00,05, FF,FF,FF,FF -> eight strobes at addresses 0..7 with data 20,01,00,05,FF,FF,FF,FF. o_cpu_reset pulses once. Then o_tx_data=8'h4B held while i_tx_ready=0; returns to IDLE one cycle after i_tx_ready=1.
- 'L' then bytes 00,FF,FF,FF, FF,00 -> no 'K'. The sentinel is only detected at aligned words; writes continue at addresses 4,5.
- 'L' with ADDR_WIDTH=4 and 16 non-sentinel bytes -> 16 strobes at 0..15, then ack 'E'.
- 'R' accepted, i_halted raised 10 cycles later -> o_stall low exactly 10 cycles, then ack 'H'. Bytes sent during RUN produce no effect.
- With DEBUG_STEP_EN: 'S' -> o_stall low exactly 1 cycle, then ack 'D'. Without DEBUG_STEP_EN: 'S' -> o_state stays 0 and no ack.

Source files
------------

// File: rtl/pipeline_debug_controller.sv
// Debug sequencer between the UART byte stream and the fetch stage: loads a program,
// runs or single-steps the pipeline, and acknowledges each command. Optional: DEBUG_STEP_EN.
module pipeline_debug_controller #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_tx_ready,
  input  logic        i_halted,
  output logic        o_write_instruction_mem,
  output logic [31:0] o_instruction_mem_addr,
  output logic [31:0] o_instruction_mem_data,
  output logic        o_stall,
  output logic        o_cpu_reset,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic [2:0]  o_state
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
`ifdef DEBUG_STEP_EN
  localparam logic [7:0] CMD_STEP = 8'h53;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
`ifdef DEBUG_STEP_EN
    STEP = 3'd3,
`endif
    ACK  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [23:0]           hist_q, hist_d;
  logic [31:0]           word_w;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  stall_q, stall_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;

  // The three previous bytes plus the incoming one form the candidate word.
  assign word_w = {hist_q, i_rx_data};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hist_d     = hist_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d   = LOAD;
            cnt_d     = '0;
            hist_d    = '0;
            cpu_rst_d = 1'b1;
          end else if (i_rx_data == CMD_RUN) begin
            state_d = RUN;
`ifdef DEBUG_STEP_EN
          end else if (i_rx_data == CMD_STEP) begin
            state_d = STEP;
`endif
          end
        end
      end
      LOAD: begin
        if (i_rx_valid) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = i_rx_data;
          hist_d  = word_w[23:0];
          if (cnt_q[1:0] == 2'b11 && word_w == 32'hFFFF_FFFF) begin
            state_d    = ACK;
            tx_data_d  = 8'h4B;
            tx_valid_d = 1'b1;
          end else if (cnt_q == LAST_ADDR) begin
            state_d    = ACK;
            tx_data_d  = 8'h45;
            tx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      RUN: begin
        if (i_halted) begin
          state_d    = ACK;
          tx_data_d  = 8'h48;
          tx_valid_d = 1'b1;
        end
      end
`ifdef DEBUG_STEP_EN
      STEP: begin
        state_d    = ACK;
        tx_data_d  = 8'h44;
        tx_valid_d = 1'b1;
      end
`endif
      ACK: begin
        if (tx_valid_q && i_tx_ready) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DEBUG_STEP_EN
    stall_d = !(state_d == RUN || state_d == STEP);
`else
    stall_d = (state_d != RUN);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hist_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      stall_q    <= 1'b1;
      cpu_rst_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hist_q     <= hist_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      stall_q    <= stall_d;
      cpu_rst_q  <= cpu_rst_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign o_state                 = state_q;
  assign o_stall                 = stall_q;
  assign o_write_instruction_mem = we_q;
  assign o_instruction_mem_addr  = {{(32-ADDR_WIDTH){1'b0}}, waddr_q};
  assign o_instruction_mem_data  = {24'd0, wdata_q};
  assign o_cpu_reset             = cpu_rst_q;
  assign o_tx_data               = tx_data_q;
  assign o_tx_valid              = tx_valid_q;

endmodule
